tetris_nios_key_input: RTL and testbench

- Avalon-MM slave input PIO for the board push-buttons; it is the read-side counterpart of the HEX output ports.
- Synchronises and debounces the raw key lines, and latches each press in a per-bit edge-capture register.
- Raises a maskable interrupt so the Nios II Tetris game loop can take moves and rotations without polling.
- Sits on the Nios data master interconnect beside the HEX PIOs.

---
 rtl/tetris_nios_key_input_pkg.sv | 16 +
 rtl/tetris_nios_key_input_if.sv | 27 ++
 rtl/tetris_nios_key_debounce.sv | 52 +++++
 rtl/tetris_nios_key_input.sv | 85 ++++++++
 tb/tb_tetris_nios_key_input.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/tetris_nios_key_input_pkg.sv
// Shared constants for the Tetris Nios PIO slaves.
// Register word addresses and the default debounce length.
package tetris_nios_key_input_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int DEBOUNCE_DEFAULT = 50000;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tetris_nios_key_input_if.sv
// Avalon-MM slave bus bundle for the key input PIO.
// The CPU side owns the request, the PIO owns readdata.
interface tetris_nios_key_input_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/tetris_nios_key_debounce.sv
// One key line: two-flop synchroniser, persistence counter, stable flop.
// A level is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
module tetris_nios_key_debounce
    import tetris_nios_key_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/tetris_nios_key_input.sv
// Push-button input PIO: debounced level, press capture, maskable irq.
// Registers: DATA, IRQMASK and write-1-to-clear EDGECAP.
module tetris_nios_key_input
    import tetris_nios_key_input_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    tetris_nios_key_input_if.slave    bus,
    input  logic [WIDTH-1:0]          in_port,
    output logic                      irq
);

    logic [WIDTH-1:0] pressed_raw;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic             wr;
    logic             rd;
    logic             unused_wdata;

    assign pressed_raw  = in_port ^ {WIDTH{ACTIVE_LOW != 0}};
    assign wr           = bus.chipselect & ~bus.write_n;
    assign rd           = bus.chipselect & bus.write_n;
    assign unused_wdata = ^bus.writedata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_key
        tetris_nios_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (pressed_raw[g]),
            .stable (stable[g])
        );
    end

    always_comb begin
        mask_d  = mask_q;
        cap_d   = cap_q;
        rdata_d = rdata_q;
        if (wr && bus.address == ADDR_IRQMASK) begin
            mask_d = bus.writedata[WIDTH-1:0];
        end
        if (wr && bus.address == ADDR_EDGECAP) begin
            cap_d = cap_q & ~bus.writedata[WIDTH-1:0];
        end
        // A press landing with a clear of the same bit must survive
        cap_d = cap_d | (stable & ~prev_q);
        if (rd) begin
            case (bus.address)
                ADDR_DATA:    rdata_d = 32'(stable);
                ADDR_IRQMASK: rdata_d = 32'(mask_q);
                ADDR_EDGECAP: rdata_d = 32'(cap_q);
                default:      rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q  <= '0;
            mask_q  <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
        end else begin
            prev_q  <= stable;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign irq          = |(cap_q & mask_q);

endmodule

// File: tb/tb_tetris_nios_key_input.sv
// Bench for the key input PIO: directed scenarios then random traffic,
// every cycle compared with a behavioural model of the register file.
module tb_tetris_nios_key_input;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] kin = '1;
    logic         irq;

    always #5 clk = ~clk;

    tetris_nios_key_input_if bus ();

    tetris_nios_key_input #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave),
        .in_port(kin),
        .irq    (irq)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Model: key samples two edges old, run length of disagreement
    logic [W-1:0] h1, h2, m_stable, m_prev, m_mask, m_cap;
    int           run [W];
    logic [31:0]  m_rd;
    logic         m_irq;

    task automatic model_reset();
        h1 = '0; h2 = '0; m_stable = '0; m_prev = '0;
        m_mask = '0; m_cap = '0; m_rd = '0; m_irq = 1'b0;
        for (int i = 0; i < W; i++) run[i] = 0;
    endtask

    task automatic model_edge(input logic [1:0] a, input logic cs,
                              input logic wn, input logic [31:0] wd);
        logic [W-1:0] nst;
        logic [W-1:0] rise;
        nst  = m_stable;
        rise = m_stable & ~m_prev;
        for (int i = 0; i < W; i++) begin
            if (h2[i] != m_stable[i]) begin
                run[i]++;
                if (run[i] == D) begin
                    nst[i] = h2[i];
                    run[i] = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
        if (cs && wn) begin
            if (a == 2'd0) m_rd = 32'(m_stable);
            else if (a == 2'd2) m_rd = 32'(m_mask);
            else if (a == 2'd3) m_rd = 32'(m_cap);
            else m_rd = 32'd0;
        end
        if (cs && !wn && a == 2'd2) m_mask = wd[W-1:0];
        if (cs && !wn && a == 2'd3) m_cap = m_cap & ~wd[W-1:0];
        m_cap    = m_cap | rise;
        h2       = h1;
        h1       = ~kin;
        m_prev   = m_stable;
        m_stable = nst;
        m_irq    = |(m_cap & m_mask);
    endtask

    task automatic cycle(input logic [1:0] a, input logic cs,
                         input logic wn, input logic [31:0] wd);
        bus.address    = a;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.writedata  = wd;
        @(posedge clk);
        model_edge(a, cs, wn, wd);
        #1;
        chk("model_rd", bus.readdata, m_rd);
        chk("model_irq", {31'b0, irq}, {31'b0, m_irq});
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        cycle(a, 1'b1, 1'b1, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cycle(a, 1'b1, 1'b0, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(2'd0, 1'b0, 1'b1, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_rd", bus.readdata, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int first;

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            chk("t1_rd", bus.readdata, 32'd0);
        end
        chk("t1_irq", {31'b0, irq}, 32'd0);

        kin   = 4'b1110;
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            rd(2'd0);
            if (first < 0 && bus.readdata[0]) first = k;
        end
        chk("t2_latency", 32'(first), 32'd7);
        chk("t2_data", bus.readdata, 32'd1);
        rd(2'd3);
        chk("t2_edgecap", bus.readdata, 32'd1);
        chk("t2_irq", {31'b0, irq}, 32'd0);

        wr(2'd2, 32'hFFFF_FFF1);
        chk("t3_irq_on", {31'b0, irq}, 32'd1);
        rd(2'd2);
        chk("t3_mask", bus.readdata, 32'd1);
        wr(2'd3, 32'd1);
        chk("t3_irq_off", {31'b0, irq}, 32'd0);
        rd(2'd3);
        chk("t3_edgecap", bus.readdata, 32'd0);

        kin = 4'b1010;
        idle(3);
        kin = 4'b1110;
        idle(6);
        rd(2'd0);
        chk("t4_data", bus.readdata, 32'd1);
        rd(2'd3);
        chk("t4_edgecap", bus.readdata, 32'd0);

        kin = 4'b0110;
        idle(6);
        wr(2'd3, 32'd8);
        rd(2'd3);
        chk("t5_setwins", bus.readdata, 32'd8);
        wr(2'd3, 32'd1);
        rd(2'd3);
        chk("t5_other_w1c", bus.readdata, 32'd8);
        chk("t5_irq", {31'b0, irq}, 32'd0);
        rd(2'd1);
        chk("t5_rsvd", bus.readdata, 32'd0);

        kin = 4'b1111;
        idle(8);
        kin = 4'b1101;
        idle(2);
        do_reset();
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            rd(2'd0);
            if (first < 0 && bus.readdata[1]) first = k;
        end
        chk("t6_latency", 32'(first), 32'd7);
        rd(2'd3);
        chk("t6_edgecap", bus.readdata, 32'd2);
        rd(2'd2);
        chk("t6_mask", bus.readdata, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            int op;
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 11) == 0) kin[i] = ~kin[i];
            end
            if ($urandom_range(0, 599) == 0) do_reset();
            op = int'($urandom_range(0, 3));
            case (op)
                0: idle(1);
                1: rd(2'($urandom_range(0, 3)));
                2: wr(2'($urandom_range(0, 3)), $urandom);
                default: rd(2'd3);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
